branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor: combinational fetch prediction,
// resolve-stage mispredict detection and saturating statistics.
module branch_predictor #(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] INIT     = 2'b10,
    parameter int         STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       f_pc,
    input  logic [31:0]       f_instr,
    output logic              pred_taken,
    output logic [31:0]       pred_pc,
    input  logic              r_valid,
    input  logic [31:0]       r_pc,
    input  logic [31:0]       r_instr,
    input  logic              r_eq,
    input  logic [31:0]       r_vs,
    input  logic              r_pred_taken,
    output logic              miss,
    output logic [31:0]       rpc,
    output logic [STAT_W-1:0] n_branch,
    output logic [STAT_W-1:0] n_miss
);
    localparam int DEPTH = 1 << IDX_BITS;

    localparam logic [2:0] K_OTHER = 3'd0;
    localparam logic [2:0] K_BEQ   = 3'd1;
    localparam logic [2:0] K_BNE   = 3'd2;
    localparam logic [2:0] K_JMP   = 3'd3;
    localparam logic [2:0] K_JR    = 3'd4;

    function automatic logic [2:0] op_kind(input logic [31:0] instr);
        logic [2:0] k;
        k = K_OTHER;
        case (instr[31:26])
            6'b000100: k = K_BEQ;
            6'b000101: k = K_BNE;
            6'b000010,
            6'b000011: k = K_JMP;
            6'b000000: k = (instr[5:0] == 6'b001000) ? K_JR : K_OTHER;
            default:   k = K_OTHER;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] pc,
                                              input logic [31:0] instr);
        return pc + 32'd4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    function automatic logic [31:0] j_target(input logic [31:0] pc,
                                             input logic [31:0] instr);
        return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, instr[25:0], 2'b00};
    endfunction

    logic [1:0]          ctr_q [DEPTH];
    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] r_idx;
    logic [2:0]          f_kind;
    logic [2:0]          r_kind;
    logic                r_is_br;
    logic                r_taken;

    assign f_idx   = f_pc[IDX_BITS+1:2];
    assign r_idx   = r_pc[IDX_BITS+1:2];
    assign f_kind  = op_kind(f_instr);
    assign r_kind  = op_kind(r_instr);
    assign r_is_br = (r_kind == K_BEQ) || (r_kind == K_BNE);
    assign r_taken = (r_kind == K_BEQ) ? r_eq : !r_eq;

    // Fetch-side prediction straight from the current table contents.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = f_pc + 32'd4;
        case (f_kind)
            K_BEQ, K_BNE: begin
                pred_taken = ctr_q[f_idx][1];
                if (ctr_q[f_idx][1])
                    pred_pc = br_target(f_pc, f_instr);
            end
            K_JMP: begin
                pred_taken = 1'b1;
                pred_pc    = j_target(f_pc, f_instr);
            end
            default: ;
        endcase
    end

    // Resolve-side mispredict detection and recovery PC.
    always_comb begin
        miss = 1'b0;
        rpc  = r_pc + 32'd4;
        if (r_valid && !reset) begin
            if (r_is_br && (r_taken != r_pred_taken)) begin
                miss = 1'b1;
                rpc  = r_taken ? br_target(r_pc, r_instr) : r_pc + 32'd4;
            end else if (r_kind == K_JR) begin
                miss = 1'b1;
                rpc  = r_vs;
            end
        end
    end

    // Saturating 2-bit counter training on resolved conditional branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                ctr_q[i] <= INIT;
        end else if (r_valid && r_is_br) begin
            if (r_taken) begin
                if (ctr_q[r_idx] != 2'b11)
                    ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
            end else if (ctr_q[r_idx] != 2'b00) begin
                ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
            end
        end
    end

    // Saturating branch and mispredict statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_branch <= '0;
            n_miss   <= '0;
        end else begin
            if (r_valid && r_is_br && (n_branch != '1))
                n_branch <= n_branch + STAT_W'(1);
            if (miss && (n_miss != '1))
                n_miss <= n_miss + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a default instance and a
// small one (IDX_BITS=2, STAT_W=2) driven in lockstep against a model.
`timescale 1ns/1ps
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [31:0] f_pc, f_instr, r_pc, r_instr, r_vs;
    logic        r_valid, r_eq, r_pred_taken;

    logic        a_pt, b_pt, a_miss, b_miss;
    logic [31:0] a_ppc, b_ppc, a_rpc, b_rpc;
    logic [15:0] a_nb, a_nm;
    logic [1:0]  b_nb, b_nm;

    int n_checks = 0;
    int n_fail   = 0;

    int mc_a [64];
    int mc_b [4];
    int nb_a, nm_a, nb_b, nm_b;

    branch_predictor u_a (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_instr(f_instr),
        .pred_taken(a_pt), .pred_pc(a_ppc), .r_valid(r_valid),
        .r_pc(r_pc), .r_instr(r_instr), .r_eq(r_eq), .r_vs(r_vs),
        .r_pred_taken(r_pred_taken), .miss(a_miss), .rpc(a_rpc),
        .n_branch(a_nb), .n_miss(a_nm)
    );

    branch_predictor #(.IDX_BITS(2), .INIT(2'b10), .STAT_W(2)) u_b (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_instr(f_instr),
        .pred_taken(b_pt), .pred_pc(b_ppc), .r_valid(r_valid),
        .r_pc(r_pc), .r_instr(r_instr), .r_eq(r_eq), .r_vs(r_vs),
        .r_pred_taken(r_pred_taken), .miss(b_miss), .rpc(b_rpc),
        .n_branch(b_nb), .n_miss(b_nm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] mk_beq(input logic [15:0] imm);
        return {6'b000100, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] mk_bne(input logic [15:0] imm);
        return {6'b000101, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] mk_jr();
        return {6'b000000, 5'd31, 15'd0, 6'b001000};
    endfunction

    // ---------------- reference model ----------------
    // kind: 0 other, 1 beq, 2 bne, 3 j/jal, 4 jr
    function automatic int m_kind(input logic [31:0] ins);
        if (ins[31:26] == 6'd4) return 1;
        if (ins[31:26] == 6'd5) return 2;
        if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) return 3;
        if (ins[31:26] == 6'd0 && ins[5:0] == 6'd8) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] m_btgt(input logic [31:0] pc,
                                           input logic [31:0] ins);
        int off;
        off = $signed(ins[15:0]);
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    function automatic logic [31:0] m_jtgt(input logic [31:0] pc,
                                           input logic [31:0] ins);
        logic [31:0] seq;
        seq = pc + 32'd4;
        return {seq[31:28], ins[25:0], 2'b00};
    endfunction

    task automatic m_pred(input int ctr, output bit t, output logic [31:0] npc);
        int k;
        k = m_kind(f_instr);
        t = 1'b0;
        npc = f_pc + 32'd4;
        if (k == 1 || k == 2) begin
            t = (ctr >= 2);
            if (t) npc = m_btgt(f_pc, f_instr);
        end else if (k == 3) begin
            t = 1'b1;
            npc = m_jtgt(f_pc, f_instr);
        end
    endtask

    task automatic m_resolve(output bit m, output logic [31:0] rp);
        int k;
        bit tk;
        k = m_kind(r_instr);
        m = 1'b0;
        rp = 32'd0;
        if (!reset && r_valid) begin
            if (k == 1 || k == 2) begin
                tk = (k == 1) ? r_eq : !r_eq;
                if (tk != r_pred_taken) begin
                    m = 1'b1;
                    rp = tk ? m_btgt(r_pc, r_instr) : r_pc + 32'd4;
                end
            end else if (k == 4) begin
                m = 1'b1;
                rp = r_vs;
            end
        end
    endtask

    task automatic m_reset();
        foreach (mc_a[i]) mc_a[i] = 2;
        foreach (mc_b[i]) mc_b[i] = 2;
        nb_a = 0; nm_a = 0; nb_b = 0; nm_b = 0;
    endtask

    task automatic m_clock();
        bit m, tk;
        logic [31:0] rp;
        int k, ia, ib;
        if (reset) begin
            m_reset();
            return;
        end
        m_resolve(m, rp);
        k = m_kind(r_instr);
        if (r_valid && (k == 1 || k == 2)) begin
            tk = (k == 1) ? r_eq : !r_eq;
            ia = int'(r_pc[7:2]);
            ib = int'(r_pc[3:2]);
            mc_a[ia] = tk ? ((mc_a[ia] < 3) ? mc_a[ia] + 1 : 3)
                          : ((mc_a[ia] > 0) ? mc_a[ia] - 1 : 0);
            mc_b[ib] = tk ? ((mc_b[ib] < 3) ? mc_b[ib] + 1 : 3)
                          : ((mc_b[ib] > 0) ? mc_b[ib] - 1 : 0);
            if (nb_a < 65535) nb_a++;
            if (nb_b < 3) nb_b++;
        end
        if (m) begin
            if (nm_a < 65535) nm_a++;
            if (nm_b < 3) nm_b++;
        end
    endtask

    // ---------------- sequencing helpers ----------------
    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r_valid = 1'b0;
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        f_pc = 32'h100;
        f_instr = mk_beq(16'h0004);
        r_valid = 1'b1;
        r_instr = mk_jr();
        r_pc = 32'h80;
        r_vs = 32'h1234;
        #1;
        n_checks++;
        if ({a_pt, a_ppc} !== {1'b1, 32'h114}) begin
            n_fail++;
            $display("FAIL reset_pred_a: got %b/%h want 1/00000114", a_pt, a_ppc);
        end
        n_checks++;
        if ({b_pt, b_ppc} !== {1'b1, 32'h114}) begin
            n_fail++;
            $display("FAIL reset_pred_b: got %b/%h want 1/00000114", b_pt, b_ppc);
        end
        n_checks++;
        if ({a_miss, b_miss} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_miss: got %b%b want 00", a_miss, b_miss);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({a_nb, a_nm, b_nb, b_nm} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d %0d %0d %0d want 0", a_nb, a_nm, b_nb, b_nm);
        end
        reset = 1'b0;
        r_valid = 1'b0;
        m_reset();
        #1;
    endtask

    task automatic test_bne_mispredict();
        r_valid = 1'b1;
        r_pc = 32'h200;
        r_instr = mk_bne(16'h0010);
        r_eq = 1'b1;
        r_pred_taken = 1'b1;
        #1;
        n_checks++;
        if ({a_miss, a_rpc} !== {1'b1, 32'h204}) begin
            n_fail++;
            $display("FAIL bne_miss: got %b/%h want 1/00000204", a_miss, a_rpc);
        end
        tick();
        r_pred_taken = 1'b0;
        #1;
        n_checks++;
        if ({a_miss, b_miss} !== 2'b00) begin
            n_fail++;
            $display("FAIL bne_nomiss: got %b%b want 00", a_miss, b_miss);
        end
        tick();
        r_valid = 1'b0;
        f_pc = 32'h200;
        f_instr = mk_bne(16'h0010);
        #1;
        n_checks++;
        if ({a_pt, a_ppc, b_pt} !== {1'b0, 32'h204, 1'b0}) begin
            n_fail++;
            $display("FAIL bne_pred: got %b/%h/%b want 0/00000204/0", a_pt, a_ppc, b_pt);
        end
        n_checks++;
        if ({a_nm, a_nb} !== {16'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL bne_stats: got nm=%0d nb=%0d want nm=1 nb=2", a_nm, a_nb);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        r_valid = 1'b1;
        r_pc = 32'h300;
        r_instr = mk_beq(16'hFFFC);
        r_eq = 1'b1;
        r_pred_taken = 1'b0;
        #1;
        n_checks++;
        if ({a_miss, a_rpc} !== {1'b1, 32'h2F4}) begin
            n_fail++;
            $display("FAIL sat_target: got %b/%h want 1/000002f4", a_miss, a_rpc);
        end
        tick();
        r_pred_taken = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        r_eq = 1'b0;
        #1;
        n_checks++;
        if ({a_miss, a_rpc} !== {1'b1, 32'h304}) begin
            n_fail++;
            $display("FAIL sat_nt_miss: got %b/%h want 1/00000304", a_miss, a_rpc);
        end
        tick();
        r_valid = 1'b0;
        f_pc = 32'h300;
        f_instr = mk_beq(16'hFFFC);
        #1;
        n_checks++;
        if ({a_pt, a_ppc, b_pt} !== {1'b1, 32'h2F4, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_stay_taken: got %b/%h/%b want 1/000002f4/1", a_pt, a_ppc, b_pt);
        end
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_pt, b_pt} !== 2'b00) begin
            n_fail++;
            $display("FAIL sat_second_dec: got %b%b want 00", a_pt, b_pt);
        end
    endtask

    task automatic test_jr();
        r_valid = 1'b1;
        r_pc = 32'h500;
        r_instr = mk_jr();
        r_vs = 32'h0040_0080;
        #1;
        n_checks++;
        if ({a_miss, a_rpc, b_miss, b_rpc} !== {1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080}) begin
            n_fail++;
            $display("FAIL jr_miss: got %b/%h %b/%h want 1/00400080", a_miss, a_rpc, b_miss, b_rpc);
        end
        tick();
        r_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_miss, b_miss} !== 2'b00) begin
            n_fail++;
            $display("FAIL jr_invalid: got %b%b want 00", a_miss, b_miss);
        end
        r_pc = 32'h300;
        r_instr = mk_beq(16'hFFFC);
        r_eq = 1'b1;
        r_pred_taken = 1'b0;
        tick();
        f_pc = 32'h300;
        f_instr = mk_beq(16'hFFFC);
        #1;
        n_checks++;
        if ({a_pt, b_pt, a_miss} !== 3'b000) begin
            n_fail++;
            $display("FAIL jr_no_update: got %b%b%b want 000", a_pt, b_pt, a_miss);
        end
        n_checks++;
        if ({a_nm, a_nb} !== {16'(nm_a), 16'(nb_a)}) begin
            n_fail++;
            $display("FAIL jr_stats: got %0d/%0d want %0d/%0d", a_nm, a_nb, nm_a, nb_a);
        end
    endtask

    task automatic test_alias();
        do_reset();
        f_pc = 32'h000;
        f_instr = mk_beq(16'h0008);
        r_valid = 1'b1;
        r_pc = 32'h000;
        r_instr = mk_beq(16'h0008);
        r_eq = 1'b0;
        r_pred_taken = 1'b1;
        #1;
        n_checks++;
        if ({a_pt, b_pt, b_ppc} !== {1'b1, 1'b1, 32'h24}) begin
            n_fail++;
            $display("FAIL alias_old_value: got %b%b/%h want 11/00000024", a_pt, b_pt, b_ppc);
        end
        tick();
        r_pc = 32'h010;
        r_eq = 1'b1;
        r_pred_taken = 1'b0;
        #1;
        n_checks++;
        if ({a_pt, b_pt} !== 2'b00) begin
            n_fail++;
            $display("FAIL alias_new_value: got %b%b want 00", a_pt, b_pt);
        end
        tick();
        r_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_pt, b_pt} !== 2'b01) begin
            n_fail++;
            $display("FAIL alias_index: got %b%b want 01", a_pt, b_pt);
        end
    endtask

    task automatic rand_instr(output logic [31:0] ins);
        logic [5:0] op, fn;
        case ($urandom_range(0, 5))
            0: op = 6'd4;
            1: op = 6'd5;
            2: op = 6'd2;
            3: op = 6'd3;
            4: op = 6'd0;
            default: op = 6'($urandom_range(6, 63));
        endcase
        ins = {op, 26'($urandom)};
        if (op == 6'd0) begin
            fn = ($urandom_range(0, 2) != 0) ? 6'd8 : 6'($urandom_range(9, 63));
            ins[5:0] = fn;
        end
    endtask

    task automatic test_random();
        bit et, em;
        logic [31:0] ep, erp;
        for (int c = 0; c < 400; c++) begin
            f_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127) * 4);
            rand_instr(f_instr);
            r_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127) * 4);
            rand_instr(r_instr);
            r_valid = ($urandom_range(0, 3) != 0);
            r_eq = 1'($urandom);
            r_pred_taken = 1'($urandom);
            r_vs = $urandom;
            #1;
            m_pred(mc_a[int'(f_pc[7:2])], et, ep);
            n_checks++;
            if ({a_pt, a_ppc} !== {et, ep}) begin
                n_fail++;
                $display("FAIL rand_pred_a[%0d]: got %b/%h want %b/%h", c, a_pt, a_ppc, et, ep);
            end
            m_pred(mc_b[int'(f_pc[3:2])], et, ep);
            n_checks++;
            if ({b_pt, b_ppc} !== {et, ep}) begin
                n_fail++;
                $display("FAIL rand_pred_b[%0d]: got %b/%h want %b/%h", c, b_pt, b_ppc, et, ep);
            end
            m_resolve(em, erp);
            n_checks++;
            if ({a_miss, a_miss ? a_rpc : 32'd0, b_miss, b_miss ? b_rpc : 32'd0}
                !== {em, erp, em, erp}) begin
                n_fail++;
                $display("FAIL rand_miss[%0d]: got %b/%h %b/%h want %b/%h",
                         c, a_miss, a_rpc, b_miss, b_rpc, em, erp);
            end
            tick();
            n_checks++;
            if ({a_nb, a_nm, b_nb, b_nm} !== {16'(nb_a), 16'(nm_a), 2'(nb_b), 2'(nm_b)}) begin
                n_fail++;
                $display("FAIL rand_stats[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         c, a_nb, a_nm, b_nb, b_nm, nb_a, nm_a, nb_b, nm_b);
            end
        end
        r_valid = 1'b0;
    endtask

    task automatic test_stat_sat();
        do_reset();
        r_valid = 1'b1;
        r_pc = 32'h040;
        r_instr = mk_bne(16'h0001);
        r_eq = 1'b1;
        r_pred_taken = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if ({b_nm, b_nb, a_nm} !== {2'd3, 2'd3, 16'd5}) begin
            n_fail++;
            $display("FAIL stat_sat: got b_nm=%0d b_nb=%0d a_nm=%0d want 3 3 5", b_nm, b_nb, a_nm);
        end
        tick();
        n_checks++;
        if ({b_nm, a_nm} !== {2'd3, 16'd6}) begin
            n_fail++;
            $display("FAIL stat_hold: got b_nm=%0d a_nm=%0d want 3 6", b_nm, a_nm);
        end
        r_valid = 1'b0;
        f_pc = 32'h040;
        f_instr = mk_beq(16'h0001);
        #1;
        n_checks++;
        if ({a_pt, b_pt} !== 2'b00) begin
            n_fail++;
            $display("FAIL stat_trained: got %b%b want 00", a_pt, b_pt);
        end
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        n_checks++;
        if ({a_pt, b_pt, a_nm, a_nb, b_nm, b_nb} !== {2'b11, 36'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b%b %0d %0d %0d %0d want 11 0 0 0 0",
                     a_pt, b_pt, a_nm, a_nb, b_nm, b_nb);
        end
        r_valid = 1'b1;
        #1;
        n_checks++;
        if ({a_miss, b_miss} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gates_miss: got %b%b want 00", a_miss, b_miss);
        end
        tick();
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({a_pt, b_pt, a_nb} !== {2'b11, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_discard: got %b%b nb=%0d want 11 nb=0", a_pt, b_pt, a_nb);
        end
        n_checks++;
        if ({a_miss, a_rpc} !== {1'b1, 32'h044}) begin
            n_fail++;
            $display("FAIL post_reset_miss: got %b/%h want 1/00000044", a_miss, a_rpc);
        end
        tick();
        r_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_pt, b_pt, a_nb, a_nm} !== {2'b00, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL first_update: got %b%b nb=%0d nm=%0d want 00 1 1", a_pt, b_pt, a_nb, a_nm);
        end
    endtask

    initial begin
        reset = 1'b1;
        f_pc = '0;
        f_instr = '0;
        r_pc = '0;
        r_instr = '0;
        r_vs = '0;
        r_valid = 1'b0;
        r_eq = 1'b0;
        r_pred_taken = 1'b0;
        m_reset();
        #2;
        test_reset();
        test_bne_mispredict();
        test_saturate();
        test_jr();
        test_alias();
        test_random();
        test_stat_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
